// File: rtl/clkdiv_pkg.sv
// Shared constants and config clamping for the multi-channel clock divider.
package clkdiv_pkg;

    localparam int unsigned CLKDIV_DEFAULT_DIVISOR = 100;
    localparam int unsigned MIN_DIVISOR            = 2;
    localparam int unsigned MAX_WIDTH              = 64;

    typedef logic [MAX_WIDTH-1:0] wide_t;

    function automatic wide_t clamp_divisor(input wide_t divisor);
        return (divisor < wide_t'(MIN_DIVISOR)) ? wide_t'(MIN_DIVISOR) : divisor;
    endfunction

    // Expects an already-clamped divisor so high time never exceeds the period.
    function automatic wide_t clamp_high(input wide_t high, input wide_t divisor);
        return (high > divisor) ? divisor : high;
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: period counter, active/pending settings and registered outputs.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int unsigned WIDTH           = 28,
    parameter int unsigned DEFAULT_DIVISOR = CLKDIV_DEFAULT_DIVISOR
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             sync,
    input  logic             load,
    input  logic [WIDTH-1:0] load_divisor,
    input  logic [WIDTH-1:0] load_high,
    output logic             pending,
    output logic             clock_out,
    output logic             tick
);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] high;
    logic [WIDTH-1:0] pend_divisor;
    logic [WIDTH-1:0] pend_high;
    logic [WIDTH-1:0] next_divisor;
    logic [WIDTH-1:0] next_high;
    logic             wrap;
    logic             apply;

    always_comb begin
        next_divisor = WIDTH'(clamp_divisor(wide_t'(load_divisor)));
        next_high    = WIDTH'(clamp_high(wide_t'(load_high), wide_t'(next_divisor)));
    end

    assign wrap  = (count == divisor - WIDTH'(1));
    // Settings only change where the counter restarts, so no runt or stretched pulse.
    assign apply = pending && (!enable || wrap || sync);

    always_ff @(posedge clock_in) begin
        if (reset) begin
            count        <= '0;
            divisor      <= WIDTH'(DEFAULT_DIVISOR);
            high         <= WIDTH'(DEFAULT_DIVISOR / 2);
            pending      <= 1'b0;
            pend_divisor <= '0;
            pend_high    <= '0;
            clock_out    <= 1'b0;
            tick         <= 1'b0;
        end else begin
            if (load) begin
                pending      <= 1'b1;
                pend_divisor <= next_divisor;
                pend_high    <= next_high;
            end

            if (!enable) begin
                count     <= '0;
                clock_out <= 1'b0;
                tick      <= 1'b0;
            end else begin
                clock_out <= (count < high);
                tick      <= (count == '0);
                count     <= (wrap || sync) ? '0 : count + WIDTH'(1);
            end

            if (apply) begin
                divisor <= pend_divisor;
                high    <= pend_high;
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider with valid/ready per-channel reload.
// Optional CLKDIV_SYNC_EN adds a 'sync' input that phase-aligns all enabled channels.
module clock_divider_multi
    import clkdiv_pkg::*;
#(
    parameter int unsigned CHANNELS        = 4,
    parameter int unsigned WIDTH           = 28,
    parameter int unsigned DEFAULT_DIVISOR = CLKDIV_DEFAULT_DIVISOR,
    localparam int unsigned CW             = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clock_in,
    input  logic                reset,
    input  logic [CHANNELS-1:0] enable,
`ifdef CLKDIV_SYNC_EN
    input  logic                sync,
`endif
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CW-1:0]       cfg_channel,
    input  logic [WIDTH-1:0]    cfg_divisor,
    input  logic [WIDTH-1:0]    cfg_high,
    output logic [CHANNELS-1:0] clock_out,
    output logic [CHANNELS-1:0] tick
);

    logic [CHANNELS-1:0] pending;
    logic                sync_all;

`ifdef CLKDIV_SYNC_EN
    assign sync_all = sync;
`else
    assign sync_all = 1'b0;
`endif

    assign cfg_ready = (32'(cfg_channel) < CHANNELS) ? !pending[cfg_channel] : 1'b0;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
        clkdiv_channel #(
            .WIDTH           (WIDTH),
            .DEFAULT_DIVISOR (DEFAULT_DIVISOR)
        ) u_channel (
            .clock_in     (clock_in),
            .reset        (reset),
            .enable       (enable[i]),
            .sync         (sync_all),
            .load         (cfg_valid && cfg_ready && (cfg_channel == CW'(i))),
            .load_divisor (cfg_divisor),
            .load_high    (cfg_high),
            .pending      (pending[i]),
            .clock_out    (clock_out[i]),
            .tick         (tick[i])
        );
    end

endmodule
